// File: rtl/tty_tx_sequencer.sv
// Asynchronous-serial transmit sequencer: start bit, DATA_BITS data bits LSB first,
// STOP_BITS stop bits, each bit lasting 16 tick16 pulses.
module tty_tx_sequencer #(
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned STOP_BITS = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick16,
    input  logic       load,
    input  logic [7:0] data,
    input  logic       clear_flag,
    output logic       txd,
    output logic       busy,
    output logic       flag,
    output logic       frame_done
);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    localparam logic [2:0] LastData = 3'(DATA_BITS - 1);
    localparam logic [2:0] LastStop = 3'(STOP_BITS - 1);

    state_e     state_q, state_d;
    logic [3:0] phase_q, phase_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       txd_q, txd_d;
    logic       flag_q, flag_d;
    logic       frame_end;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            phase_q   <= 4'd0;
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'd0;
            txd_q     <= 1'b1;
            flag_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            txd_q     <= txd_d;
            flag_q    <= flag_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        frame_end = 1'b0;
        if (state_q == StIdle) begin
            // A tick coinciding with load is deliberately dropped: the frame starts at phase 0.
            if (load) begin
                state_d   = StStart;
                phase_d   = 4'd0;
                bit_cnt_d = 3'd0;
                shift_d   = data;
            end
        end else if (tick16) begin
            phase_d = phase_q + 4'd1;
            if (phase_q == 4'd15) begin
                case (state_q)
                    StStart: begin
                        state_d   = StData;
                        bit_cnt_d = 3'd0;
                    end
                    StData: begin
                        shift_d = shift_q >> 1;
                        if (bit_cnt_q == LastData) begin
                            state_d   = StStop;
                            bit_cnt_d = 3'd0;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end
                    StStop: begin
                        if (bit_cnt_q == LastStop) begin
                            state_d   = StIdle;
                            bit_cnt_d = 3'd0;
                            frame_end = 1'b1;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        busy       = (state_q != StIdle);
        frame_done = frame_end && !reset;
        // txd is registered from the next state so the line changes on the same edge as the FSM.
        case (state_d)
            StStart: txd_d = 1'b0;
            StData:  txd_d = shift_d[0];
            default: txd_d = 1'b1;
        endcase
        flag_d = flag_q;
        if (frame_end) begin
            flag_d = 1'b1;
        end else if ((state_q == StIdle && load) || clear_flag) begin
            flag_d = 1'b0;
        end
    end

    assign txd  = txd_q;
    assign flag = flag_q;

endmodule
